screen_arbiter: RTL and testbench



---
 rtl/screen_arbiter.sv | 165 ++++++++++++++++
 tb/tb_screen_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/screen_arbiter.sv
// Shares one single-port 8K x 16 screen RAM between timed video fetch slots and the CPU bus.
// Fetched words are serialised LSB-first into a 1-bit pixel stream, gated to the 512x256 window.
module screen_arbiter #(
    parameter int BOX_X         = 64,
    parameter int BOX_Y         = 112,
    parameter int WORDS_PER_ROW = 32,
    parameter int ROWS          = 256,
    parameter int ADDR_W        = 13
) (
    input  logic              CLK,
    input  logic              RESETB,
    input  logic [9:0]        h_count,
    input  logic [9:0]        v_count,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic [15:0]       cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic              pixel
);

    localparam int         WIN_W    = WORDS_PER_ROW * 16;
    localparam int         K_W      = $clog2(WORDS_PER_ROW);
    localparam logic [9:0] SLOT_H0  = 10'(BOX_X - 4);
    localparam logic [9:0] LOAD_H0  = 10'(BOX_X - 1);
    localparam logic [9:0] WIN_X0   = 10'(BOX_X);
    localparam logic [9:0] WIN_X1   = 10'(BOX_X + WIN_W);
    localparam logic [9:0] WIN_Y0   = 10'(BOX_Y);
    localparam logic [9:0] WIN_Y1   = 10'(BOX_Y + ROWS);
    localparam logic [9:0] WIN_SPAN = 10'(WIN_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUED,
        S_ACK
    } cpuState_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VIDEO,
        OWN_CPU
    } owner_t;

    cpuState_t         r_state;
    cpuState_t         w_nextState;
    owner_t            r_owner;
    owner_t            w_nextOwner;
    logic [ADDR_W-1:0] r_lastAddr;
    logic [15:0]       r_lastWdata;
    logic [15:0]       r_hold;
    logic [15:0]       r_shift;
    logic [15:0]       r_cpuRdata;

    logic              w_vWin;
    logic              w_hWin;
    logic              w_inBox;
    logic [9:0]        w_slotRel;
    logic [9:0]        w_loadRel;
    logic [9:0]        w_rowOff;
    logic              w_slot;
    logic              w_load;
    logic              w_grant;
    logic [K_W-1:0]    w_k;
    logic [ADDR_W-1:0] w_vidAddr;

    // Slots sit 4 pixels ahead of each 16-pixel word; the shift register reloads on the last edge before it.
    assign w_vWin    = (v_count >= WIN_Y0) && (v_count < WIN_Y1);
    assign w_hWin    = (h_count >= WIN_X0) && (h_count < WIN_X1);
    assign w_inBox   = w_vWin && w_hWin;
    assign w_slotRel = h_count - SLOT_H0;
    assign w_loadRel = h_count - LOAD_H0;
    assign w_slot    = RESETB && w_vWin && (h_count >= SLOT_H0) &&
                       (w_slotRel < WIN_SPAN) && (w_slotRel[3:0] == 4'd0);
    assign w_load    = w_vWin && (h_count >= LOAD_H0) &&
                       (w_loadRel < WIN_SPAN) && (w_loadRel[3:0] == 4'd0);
    assign w_k       = w_slotRel[K_W+3:4];
    assign w_rowOff  = v_count - WIN_Y0;
    assign w_vidAddr = (ADDR_W'(w_rowOff) * ADDR_W'(WORDS_PER_ROW)) + ADDR_W'(w_k);

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:   if (w_grant) w_nextState = S_ISSUED;
            S_ISSUED: w_nextState = S_ACK;
            S_ACK:    w_nextState = S_IDLE;
            default:  w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        w_grant = 1'b0;
        cpu_ack = 1'b0;
        case (r_state)
            S_IDLE:  w_grant = RESETB && cpu_req && !w_slot;
            S_ACK:   cpu_ack = 1'b1;
            default: ;
        endcase
    end

    // Video always wins; with no owner the address and data lines keep their last value.
    always_comb begin
        mem_addr    = r_lastAddr;
        mem_wdata   = r_lastWdata;
        mem_we      = 1'b0;
        w_nextOwner = OWN_NONE;
        if (w_slot) begin
            mem_addr    = w_vidAddr;
            w_nextOwner = OWN_VIDEO;
        end else if (w_grant) begin
            mem_addr    = cpu_addr;
            mem_wdata   = cpu_wdata;
            mem_we      = cpu_we;
            w_nextOwner = OWN_CPU;
        end
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            r_lastAddr  <= '0;
            r_lastWdata <= '0;
            r_owner     <= OWN_NONE;
        end else begin
            r_lastAddr  <= mem_addr;
            r_lastWdata <= mem_wdata;
            r_owner     <= w_nextOwner;
        end
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            r_hold     <= '0;
            r_cpuRdata <= '0;
        end else begin
            if (r_owner == OWN_VIDEO) r_hold <= mem_rdata;
            if (r_owner == OWN_CPU)   r_cpuRdata <= mem_rdata;
        end
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            r_shift <= '0;
        end else if (w_load) begin
            r_shift <= r_hold;
        end else if (w_inBox) begin
            r_shift <= {1'b0, r_shift[15:1]};
        end
    end

    assign cpu_rdata = r_cpuRdata;
    assign pixel     = w_inBox && r_shift[0];

endmodule

// File: tb/tb_screen_arbiter.sv
// Randomised bench for screen_arbiter: a RAM model, a line-by-line h/v driver and a CPU agent,
// with a scoreboard monitor checking port ownership, ack timing, read data and pixels.
module tb_screen_arbiter;

    localparam int BOX_X = 64;
    localparam int BOX_Y = 112;
    localparam int ROWS  = 256;

    logic        CLK = 1'b0;
    logic        RESETB;
    logic [9:0]  h_count;
    logic [9:0]  v_count;
    logic        cpu_req;
    logic        cpu_we;
    logic [12:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic [12:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        pixel;

    always #5 CLK = ~CLK;

    screen_arbiter #(
        .BOX_X(BOX_X), .BOX_Y(BOX_Y), .WORDS_PER_ROW(32), .ROWS(ROWS), .ADDR_W(13)
    ) dut (
        .CLK(CLK), .RESETB(RESETB), .h_count(h_count), .v_count(v_count),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pixel(pixel)
    );

    logic [15:0] ram [0:8191];
    always @(posedge CLK) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct { bit isRead; logic [12:0] addr; logic [15:0] data; } cpuExp_t;
    typedef struct { bit we; logic [12:0] addr; logic [15:0] data; } cpuOp_t;
    typedef enum { M_NONE, M_EVERY3, M_RANDREAD, M_DIRECT60, M_RESET } lineMode_t;

    logic [15:0] refMem [0:8191];
    cpuExp_t     expQ[$];
    cpuOp_t      opQ[$];
    int          readRows[5] = '{0, 1, 3, 150, 255};
    int          checkCount = 0;
    int          passCount  = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (h=%0d v=%0d)",
                      name, actual, expected, h_count, v_count);
    endtask

    function automatic bit isSlot(input int hh, input int vv);
        return (vv >= BOX_Y) && (vv < BOX_Y + ROWS) && (hh >= BOX_X - 4) &&
               (hh < BOX_X - 4 + 512) && ((hh - (BOX_X - 4)) % 16 == 0);
    endfunction

    function automatic logic [12:0] slotAddr(input int hh, input int vv);
        return 13'((vv - BOX_Y) * 32 + (hh - (BOX_X - 4)) / 16);
    endfunction

    function automatic logic expPixel(input int hh, input int vv);
        logic [15:0] word;
        if (vv < BOX_Y || vv >= BOX_Y + ROWS || hh < BOX_X || hh >= BOX_X + 512) return 1'b0;
        word = refMem[13'((vv - BOX_Y) * 32 + (hh - BOX_X) / 16)];
        return word[4'((hh - BOX_X) % 16)];
    endfunction

    // Monitor: grant goes to the first non-slot cycle with a request; ack follows two cycles later.
    int cycleNo  = 0;
    bit busy     = 0;
    int ackDue   = 0;
    bit pixCheck = 0;
    always @(negedge CLK) begin : monitor
        int      hh;
        int      vv;
        bit      slotNow;
        bit      grantNow;
        bit      ackExp;
        cpuExp_t e;
        cycleNo++;
        hh = int'(h_count);
        vv = int'(v_count);
        if (!RESETB) begin
            checkOutput("rstAck",   32'(cpu_ack),   32'd0);
            checkOutput("rstRdata", 32'(cpu_rdata), 32'd0);
            checkOutput("rstWe",    32'(mem_we),    32'd0);
            checkOutput("rstAddr",  32'(mem_addr),  32'd0);
            checkOutput("rstWdata", 32'(mem_wdata), 32'd0);
            checkOutput("rstPixel", 32'(pixel),     32'd0);
            busy     = 0;
            pixCheck = 0;
            expQ.delete();
        end else begin
            if (hh == 0) pixCheck = 1;
            slotNow  = isSlot(hh, vv);
            grantNow = cpu_req && !busy && !slotNow;
            ackExp   = busy && (cycleNo == ackDue);
            if (slotNow) begin
                checkOutput("slotAddr", 32'(mem_addr), 32'(slotAddr(hh, vv)));
                checkOutput("slotWe",   32'(mem_we),   32'd0);
            end else if (grantNow) begin
                checkOutput("grantAddr", 32'(mem_addr), 32'(cpu_addr));
                checkOutput("grantWe",   32'(mem_we),   32'(cpu_we));
                if (cpu_we) checkOutput("grantWdata", 32'(mem_wdata), 32'(cpu_wdata));
                busy   = 1;
                ackDue = cycleNo + 2;
            end else begin
                checkOutput("idleWe", 32'(mem_we), 32'd0);
            end
            checkOutput("cpuAck", 32'(cpu_ack), 32'(ackExp));
            if (ackExp) begin
                busy = 0;
                checkOutput("sbDepth", 32'(expQ.size()), 32'd1);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    if (e.isRead) checkOutput("cpuRdata", 32'(cpu_rdata), 32'(e.data));
                end
            end
            if (pixCheck) checkOutput("pixel", 32'(pixel), 32'(expPixel(hh, vv)));
        end
    end

    task automatic issueOp(input bit we, input logic [12:0] addr, input logic [15:0] data);
        cpuExp_t e;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = data;
        e.isRead  = !we;
        e.addr    = addr;
        e.data    = we ? data : refMem[addr];
        if (we) refMem[addr] = data;
        expQ.push_back(e);
    endtask

    // Random writes stay in rows 1 and 150 so the directed words in rows 0, 3 and 255 survive.
    task automatic randomOp(input bit allowWrite);
        int row;
        if (allowWrite && ($urandom_range(0, 1) == 1)) begin
            row = ($urandom_range(0, 1) == 1) ? 1 : 150;
            issueOp(1'b1, 13'(row * 32 + int'($urandom_range(0, 31))), 16'($urandom));
        end else begin
            row = readRows[$urandom_range(0, 4)];
            issueOp(1'b0, 13'(row * 32 + int'($urandom_range(0, 31))), 16'($urandom));
        end
    endtask

    task automatic applyStimulus(input int hh, input int vv, input lineMode_t mode);
        bit     ackSeen;
        cpuOp_t op;
        @(negedge CLK);
        ackSeen = cpu_ack;
        @(posedge CLK);
        #1;
        h_count = 10'(hh);
        v_count = 10'(vv);
        if (ackSeen) cpu_req = 1'b0;
        if (!cpu_req) begin
            case (mode)
                M_NONE: if (opQ.size() > 0) begin
                    op = opQ.pop_front();
                    issueOp(op.we, op.addr, op.data);
                end
                M_EVERY3:   randomOp(1'b1);
                M_RANDREAD: if ($urandom_range(0, 3) == 0) randomOp(1'b0);
                M_DIRECT60: begin
                    if (hh == 60) issueOp(1'b1, 13'd8000, 16'h1234);
                    else if (hh > 100 && $urandom_range(0, 3) == 0) randomOp(1'b0);
                end
                M_RESET: if (hh == 200 || hh == 210) randomOp(1'b0);
                default: ;
            endcase
        end
        if (mode == M_RESET && hh == 201) begin
            #2;
            RESETB  = 1'b0;
            cpu_req = 1'b0;
        end
        if (mode == M_RESET && hh == 205) RESETB = 1'b1;
    endtask

    task automatic runLine(input int vv, input lineMode_t mode);
        for (int hh = 0; hh < 800; hh++) applyStimulus(hh, vv, mode);
    endtask

    task automatic queueOp(input bit we, input int addr, input logic [15:0] data);
        cpuOp_t op;
        op.we   = we;
        op.addr = 13'(addr);
        op.data = data;
        opQ.push_back(op);
    endtask

    initial begin
        RESETB    = 1'b0;
        h_count   = '0;
        v_count   = '0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        for (int i = 0; i < 8192; i++) refMem[13'(i)] = 16'h0000;
        foreach (readRows[r]) begin
            for (int k = 0; k < 32; k++) queueOp(1'b1, readRows[r] * 32 + k, 16'($urandom));
        end
        queueOp(1'b1, 0,    16'h0001);
        queueOp(1'b1, 8191, 16'h8000);
        queueOp(1'b1, 100,  16'hA5C3);
        queueOp(1'b1, 96,   16'hA5C3);
        queueOp(1'b0, 100,  16'h0000);
        queueOp(1'b0, 0,    16'h0000);
        queueOp(1'b0, 8191, 16'h0000);

        repeat (3) @(posedge CLK);
        #1 RESETB = 1'b1;

        runLine(0,   M_NONE);
        runLine(111, M_EVERY3);
        runLine(112, M_DIRECT60);
        runLine(113, M_RESET);
        runLine(115, M_RANDREAD);
        runLine(262, M_RANDREAD);
        runLine(367, M_RANDREAD);
        runLine(368, M_EVERY3);
        runLine(200, M_NONE);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
